// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl
//   Controller and storage for a 4-way fully associative victim cache that sits
//   between L1 and L2/pmem. L1 inserts its evicted lines here and probes here on
//   an L1 miss. A probe hit returns the line to L1 and drops the entry, so a line
//   is never held in both caches. Dirty victims are written back to pmem before
//   their way is reused. Victim choice is the lowest-index invalid way, or the
//   way reported by the external LRU unit when all four ways are valid.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   l1_read / l1_write       probe / insert request, held until l1_resp
//   l1_addr                  line address (offset bits ignored)
//   l1_wdata, l1_wdirty      evicted line and its dirty flag (insert)
//   l1_resp                  one-cycle completion pulse
//   l1_rdata, l1_rdirty      returned line and dirty flag (probe)
//   pmem_read / pmem_write   L2 request, held until pmem_resp
//   pmem_addr, pmem_wdata    line-aligned address and write-back data
//   pmem_rdata, pmem_resp    fill data and L2 completion pulse
//   lru                      least recently used way from the LRU unit
//   load_lru, new_access     one-cycle touch strobe and touched way
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for an L1 request; write wins if both are raised
// S_LOOKUP | tag compare on the latched request, pick victim on insert miss
// S_WB     | writing the dirty victim back to pmem
// S_FILL   | probe missed here, fetching the line from pmem for L1
// S_RESP   | l1_resp pulse, back to S_IDLE

module victim_cache_ctrl #(
   parameter int ADDR_BITS   = 32,
   parameter int OFFSET_BITS = 5,
   parameter int LINE_BITS   = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 l1_read,
   input  logic                 l1_write,
   input  logic [ADDR_BITS-1:0] l1_addr,
   input  logic [LINE_BITS-1:0] l1_wdata,
   input  logic                 l1_wdirty,
   output logic                 l1_resp,
   output logic [LINE_BITS-1:0] l1_rdata,
   output logic                 l1_rdirty,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [ADDR_BITS-1:0] pmem_addr,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp,
   input  logic [1:0]           lru,
   output logic                 load_lru,
   output logic [1:0]           new_access
);

   localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS;
   localparam int NUM_WAYS = 4;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [NUM_WAYS-1:0]   valid_q, valid_d;
   logic [NUM_WAYS-1:0]   dirty_q, dirty_d;
   logic [TAG_BITS-1:0]   tag_q  [NUM_WAYS];
   logic [TAG_BITS-1:0]   tag_d  [NUM_WAYS];
   logic [LINE_BITS-1:0]  data_q [NUM_WAYS];
   logic [LINE_BITS-1:0]  data_d [NUM_WAYS];

   logic                  op_wr_q, op_wr_d;
   logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
   logic [LINE_BITS-1:0]  req_data_q, req_data_d;
   logic                  req_dirty_q, req_dirty_d;
   logic [1:0]            victim_q, victim_d;

   logic [LINE_BITS-1:0]  l1_rdata_q, l1_rdata_d;
   logic                  l1_rdirty_q, l1_rdirty_d;
   logic                  pmem_read_q, pmem_read_d;
   logic                  pmem_write_q, pmem_write_d;
   logic [ADDR_BITS-1:0]  pmem_addr_q, pmem_addr_d;
   logic [LINE_BITS-1:0]  pmem_wdata_q, pmem_wdata_d;
   logic                  load_lru_q, load_lru_d;
   logic [1:0]            new_access_q, new_access_d;

   logic                  hit;
   logic [1:0]            hit_way;
   logic [1:0]            alloc_way;
   logic                  unused_offset;

   assign unused_offset = ^l1_addr[OFFSET_BITS-1:0];

   // Tag match against the latched request; the exclusive policy guarantees at
   // most one valid way can match.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      alloc_way = lru;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
            hit     = 1'b1;
            hit_way = 2'(i);
         end
      end
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            alloc_way = 2'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      tag_d        = tag_q;
      data_d       = data_q;
      op_wr_d      = op_wr_q;
      req_tag_d    = req_tag_q;
      req_data_d   = req_data_q;
      req_dirty_d  = req_dirty_q;
      victim_d     = victim_q;
      l1_rdata_d   = l1_rdata_q;
      l1_rdirty_d  = l1_rdirty_q;
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
      pmem_addr_d  = pmem_addr_q;
      pmem_wdata_d = pmem_wdata_q;
      load_lru_d   = 1'b0;
      new_access_d = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (l1_write) begin
               op_wr_d     = 1'b1;
               req_tag_d   = l1_addr[ADDR_BITS-1:OFFSET_BITS];
               req_data_d  = l1_wdata;
               req_dirty_d = l1_wdirty;
               state_d     = S_LOOKUP;
            end else if (l1_read) begin
               op_wr_d   = 1'b0;
               req_tag_d = l1_addr[ADDR_BITS-1:OFFSET_BITS];
               state_d   = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (!op_wr_q) begin
               if (hit) begin
                  l1_rdata_d       = data_q[hit_way];
                  l1_rdirty_d      = dirty_q[hit_way];
                  valid_d[hit_way] = 1'b0;
                  dirty_d[hit_way] = 1'b0;
                  state_d          = S_RESP;
               end else begin
                  pmem_read_d = 1'b1;
                  pmem_addr_d = {req_tag_q, {OFFSET_BITS{1'b0}}};
                  state_d     = S_FILL;
               end
            end else if (hit) begin
               data_d[hit_way]  = req_data_q;
               dirty_d[hit_way] = dirty_q[hit_way] | req_dirty_q;
               load_lru_d       = 1'b1;
               new_access_d     = hit_way;
               state_d          = S_RESP;
            end else begin
               // Victim is frozen here so an LRU update during write-back
               // cannot redirect the install.
               victim_d = alloc_way;
               if (valid_q[alloc_way] && dirty_q[alloc_way]) begin
                  pmem_write_d = 1'b1;
                  pmem_addr_d  = {tag_q[alloc_way], {OFFSET_BITS{1'b0}}};
                  pmem_wdata_d = data_q[alloc_way];
                  state_d      = S_WB;
               end else begin
                  valid_d[alloc_way] = 1'b1;
                  dirty_d[alloc_way] = req_dirty_q;
                  tag_d[alloc_way]   = req_tag_q;
                  data_d[alloc_way]  = req_data_q;
                  load_lru_d         = 1'b1;
                  new_access_d       = alloc_way;
                  state_d            = S_RESP;
               end
            end
         end

         S_WB: begin
            if (pmem_resp) begin
               pmem_write_d      = 1'b0;
               valid_d[victim_q] = 1'b1;
               dirty_d[victim_q] = req_dirty_q;
               tag_d[victim_q]   = req_tag_q;
               data_d[victim_q]  = req_data_q;
               load_lru_d        = 1'b1;
               new_access_d      = victim_q;
               state_d           = S_RESP;
            end
         end

         S_FILL: begin
            if (pmem_resp) begin
               pmem_read_d = 1'b0;
               l1_rdata_d  = pmem_rdata;
               l1_rdirty_d = 1'b0;
               state_d     = S_RESP;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         op_wr_q      <= 1'b0;
         req_tag_q    <= '0;
         req_data_q   <= '0;
         req_dirty_q  <= 1'b0;
         victim_q     <= 2'd0;
         l1_rdata_q   <= '0;
         l1_rdirty_q  <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         pmem_addr_q  <= '0;
         pmem_wdata_q <= '0;
         load_lru_q   <= 1'b0;
         new_access_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         op_wr_q      <= op_wr_d;
         req_tag_q    <= req_tag_d;
         req_data_q   <= req_data_d;
         req_dirty_q  <= req_dirty_d;
         victim_q     <= victim_d;
         l1_rdata_q   <= l1_rdata_d;
         l1_rdirty_q  <= l1_rdirty_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
         pmem_addr_q  <= pmem_addr_d;
         pmem_wdata_q <= pmem_wdata_d;
         load_lru_q   <= load_lru_d;
         new_access_q <= new_access_d;
      end
   end

   // Line storage is not reset; the valid bits gate every use. Writes are
   // blocked during reset so an interrupted write-back leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   assign l1_resp    = (state_q == S_RESP);
   assign l1_rdata   = l1_rdata_q;
   assign l1_rdirty  = l1_rdirty_q;
   assign pmem_read  = pmem_read_q;
   assign pmem_write = pmem_write_q;
   assign pmem_addr  = pmem_addr_q;
   assign pmem_wdata = pmem_wdata_q;
   assign load_lru   = load_lru_q;
   assign new_access = new_access_q;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Bench for victim_cache_ctrl: directed scenarios plus a randomized run, all
// checked against a line-level model of the 4-way exclusive victim cache.

module tb_victim_cache_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          l1_read, l1_write;
   logic [31:0]   l1_addr;
   logic [255:0]  l1_wdata;
   logic          l1_wdirty;
   logic          l1_resp;
   logic [255:0]  l1_rdata;
   logic          l1_rdirty;
   logic          pmem_read, pmem_write;
   logic [31:0]   pmem_addr;
   logic [255:0]  pmem_wdata;
   logic [255:0]  pmem_rdata;
   logic          pmem_resp;
   logic [1:0]    lru;
   logic          load_lru;
   logic [1:0]    new_access;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   victim_cache_ctrl #(.ADDR_BITS(32), .OFFSET_BITS(5), .LINE_BITS(256)) dut (
      .clk(clk), .rst(rst),
      .l1_read(l1_read), .l1_write(l1_write), .l1_addr(l1_addr),
      .l1_wdata(l1_wdata), .l1_wdirty(l1_wdirty),
      .l1_resp(l1_resp), .l1_rdata(l1_rdata), .l1_rdirty(l1_rdirty),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .lru(lru), .load_lru(load_lru), .new_access(new_access)
   );

   // Reference model: four line slots.
   bit           m_valid [4];
   bit           m_dirty [4];
   logic [26:0]  m_tag   [4];
   logic [255:0] m_data  [4];

   typedef struct {
      bit           wb;
      bit           fill;
      logic [1:0]   way;
      logic [31:0]  paddr;
      logic [255:0] pwdata;
      logic [255:0] rdata;
      logic         rdirty;
      int           n_load;
   } exp_t;

   typedef struct {
      int           resp_cyc;
      int           pmem_cyc;
      bit           timeout;
      int           n_load;
      logic [1:0]   last_na;
      bit           saw_rd;
      bit           saw_wr;
      bit           both;
      bit           unstable;
      logic [31:0]  paddr;
      logic [255:0] pwdata;
      logic [255:0] rdata;
      logic         rdirty;
   } obs_t;

   function automatic logic [255:0] rnd_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
   endtask

   task automatic model_access(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                               input bit wdirty, input logic [1:0] lru_v,
                               input logic [255:0] fill, output exp_t e);
      logic [26:0] t;
      int          w;
      int          v;
      t = addr[31:5];
      e.wb = 0; e.fill = 0; e.way = 0; e.paddr = 0; e.pwdata = 0;
      e.rdata = 0; e.rdirty = 0; e.n_load = 0;
      w = -1;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) w = i;
      if (!wr) begin
         if (w >= 0) begin
            e.rdata    = m_data[w];
            e.rdirty   = m_dirty[w];
            m_valid[w] = 0;
         end else begin
            e.fill   = 1;
            e.paddr  = {t, 5'b0};
            e.rdata  = fill;
            e.rdirty = 0;
         end
      end else begin
         e.n_load = 1;
         if (w >= 0) begin
            m_data[w]  = wdata;
            m_dirty[w] = m_dirty[w] | wdirty;
            e.way      = 2'(w);
         end else begin
            v = -1;
            for (int i = 0; i < 4; i++) if (v < 0 && !m_valid[i]) v = i;
            if (v < 0) v = int'(lru_v);
            if (m_valid[v] && m_dirty[v]) begin
               e.wb     = 1;
               e.paddr  = {m_tag[v], 5'b0};
               e.pwdata = m_data[v];
            end
            m_valid[v] = 1;
            m_dirty[v] = wdirty;
            m_tag[v]   = t;
            m_data[v]  = wdata;
            e.way      = 2'(v);
         end
      end
   endtask

   // Drives one L1 request, plays the pmem side with a random delay, and
   // records what the DUT did; it makes no judgements itself.
   task automatic run_txn(input bit rd, input bit wr, input bit keep_rd, input logic [31:0] addr,
                          input logic [255:0] wdata, input bit wdirty, input logic [1:0] lru_v,
                          input logic [255:0] fill, output obs_t o);
      int cyc, dly;
      bit pend, given, done;
      o.resp_cyc = -1; o.pmem_cyc = -1; o.timeout = 0; o.n_load = 0; o.last_na = 0;
      o.saw_rd = 0; o.saw_wr = 0; o.both = 0; o.unstable = 0; o.paddr = 0;
      o.pwdata = 0; o.rdata = 0; o.rdirty = 0;
      cyc = 0; dly = 0; pend = 0; given = 0; done = 0;
      @(negedge clk);
      l1_read = rd; l1_write = wr; l1_addr = addr; l1_wdata = wdata;
      l1_wdirty = wdirty; lru = lru_v;
      while (!done && cyc < 64) begin
         @(negedge clk);
         cyc++;
         pmem_resp = 1'b0;
         if (load_lru) begin
            o.n_load++;
            o.last_na = new_access;
         end
         if (pmem_read && pmem_write) o.both = 1;
         if ((pmem_read || pmem_write) && !given) begin
            if (!pend) begin
               pend = 1;
               o.saw_rd = pmem_read; o.saw_wr = pmem_write;
               o.paddr = pmem_addr; o.pwdata = pmem_wdata;
               dly = $urandom_range(0, 3);
            end else if (pmem_addr !== o.paddr || pmem_wdata !== o.pwdata ||
                         pmem_read !== o.saw_rd || pmem_write !== o.saw_wr) begin
               o.unstable = 1;
            end
            if (dly == 0) begin
               pmem_rdata = fill;
               pmem_resp  = 1'b1;
               given      = 1;
               o.pmem_cyc = cyc;
            end else begin
               dly--;
            end
         end
         if (l1_resp) begin
            o.resp_cyc = cyc;
            o.rdata    = l1_rdata;
            o.rdirty   = l1_rdirty;
            done       = 1;
            l1_write   = 1'b0;
            if (!keep_rd) l1_read = 1'b0;
         end
      end
      if (!done) begin
         o.timeout = 1;
         l1_read = 1'b0; l1_write = 1'b0; pmem_resp = 1'b0;
      end
   endtask

   task automatic test_reset();
      bit bad;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (l1_resp !== 1'b0) begin n_fail++; $display("FAIL rst_l1_resp: got %b expected 0", l1_resp); end
      n_checks++; if (l1_rdata !== '0) begin n_fail++; $display("FAIL rst_l1_rdata: got %0h expected 0", l1_rdata); end
      n_checks++; if (l1_rdirty !== 1'b0) begin n_fail++; $display("FAIL rst_l1_rdirty: got %b expected 0", l1_rdirty); end
      n_checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_pmem_req: got rd=%b wr=%b expected 0", pmem_read, pmem_write); end
      n_checks++; if (pmem_addr !== '0) begin n_fail++; $display("FAIL rst_pmem_addr: got %0h expected 0", pmem_addr); end
      n_checks++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL rst_pmem_wdata: got %0h expected 0", pmem_wdata); end
      n_checks++; if (load_lru !== 1'b0 || new_access !== 2'd0) begin n_fail++; $display("FAIL rst_lru_if: got load=%b na=%0d expected 0", load_lru, new_access); end
      rst = 1'b0;
      model_clear();
      // A stray pmem_resp in IDLE must be ignored.
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (l1_resp || load_lru || pmem_read || pmem_write) bad = 1;
      end
      n_checks++; if (bad) begin n_fail++; $display("FAIL idle_pmem_resp: got activity expected none"); end
   endtask

   task automatic test_clean_inserts();
      exp_t e;
      obs_t o;
      logic [255:0] d;
      for (int i = 0; i < 4; i++) begin
         d = rnd_line();
         model_access(1, 32'h100 * (i + 1), d, 0, 2'd0, '0, e);
         run_txn(0, 1, 0, 32'h100 * (i + 1), d, 0, 2'd0, '0, o);
         n_checks++; if (o.resp_cyc !== 2) begin n_fail++; $display("FAIL ins_latency[%0d]: got %0d expected 2", i, o.resp_cyc); end
         n_checks++; if (o.n_load !== 1 || o.last_na !== 2'(i)) begin n_fail++; $display("FAIL ins_new_access[%0d]: got n=%0d na=%0d expected n=1 na=%0d", i, o.n_load, o.last_na, i); end
         n_checks++; if (o.saw_rd || o.saw_wr) begin n_fail++; $display("FAIL ins_pmem[%0d]: got rd=%b wr=%b expected none", i, o.saw_rd, o.saw_wr); end
      end
   endtask

   task automatic test_clean_evict();
      exp_t e;
      obs_t o;
      logic [255:0] d;
      d = rnd_line();
      model_access(1, 32'h500, d, 0, 2'd2, '0, e);
      run_txn(0, 1, 0, 32'h500, d, 0, 2'd2, '0, o);
      n_checks++; if (o.saw_rd || o.saw_wr) begin n_fail++; $display("FAIL evict_clean_pmem: got rd=%b wr=%b expected none", o.saw_rd, o.saw_wr); end
      n_checks++; if (o.n_load !== 1 || o.last_na !== 2'd2) begin n_fail++; $display("FAIL evict_clean_way: got n=%0d na=%0d expected n=1 na=2", o.n_load, o.last_na); end
      n_checks++; if (o.resp_cyc !== 2) begin n_fail++; $display("FAIL evict_clean_latency: got %0d expected 2", o.resp_cyc); end
   endtask

   task automatic test_dirty_wb();
      exp_t e;
      obs_t o;
      logic [255:0] b2, f;
      b2 = rnd_line();
      model_access(1, 32'h200, b2, 1, 2'd0, '0, e);
      run_txn(0, 1, 0, 32'h200, b2, 1, 2'd0, '0, o);
      n_checks++; if (o.last_na !== 2'd1 || o.saw_wr || o.resp_cyc !== 2) begin n_fail++; $display("FAIL wr_hit: got na=%0d wb=%b lat=%0d expected na=1 wb=0 lat=2", o.last_na, o.saw_wr, o.resp_cyc); end
      f = rnd_line();
      model_access(1, 32'h600, f, 1, 2'd1, '0, e);
      run_txn(0, 1, 0, 32'h600, f, 1, 2'd1, '0, o);
      n_checks++; if (!o.saw_wr || o.saw_rd) begin n_fail++; $display("FAIL wb_req: got rd=%b wr=%b expected wr only", o.saw_rd, o.saw_wr); end
      n_checks++; if (o.paddr !== 32'h200) begin n_fail++; $display("FAIL wb_addr: got %0h expected 200", o.paddr); end
      n_checks++; if (o.pwdata !== b2) begin n_fail++; $display("FAIL wb_data: got %0h expected %0h", o.pwdata, b2); end
      n_checks++; if (o.n_load !== 1 || o.last_na !== 2'd1) begin n_fail++; $display("FAIL wb_install: got n=%0d na=%0d expected n=1 na=1", o.n_load, o.last_na); end
      n_checks++; if (o.resp_cyc !== o.pmem_cyc + 1) begin n_fail++; $display("FAIL wb_latency: got %0d expected %0d", o.resp_cyc, o.pmem_cyc + 1); end
      n_checks++; if (o.unstable || o.both) begin n_fail++; $display("FAIL wb_stable: got unstable=%b both=%b expected 0", o.unstable, o.both); end
   endtask

   task automatic test_read_hit();
      exp_t e;
      obs_t o;
      logic [255:0] g, fl;
      g = rnd_line();
      model_access(1, 32'h300, g, 1, 2'd0, '0, e);
      run_txn(0, 1, 0, 32'h300, g, 1, 2'd0, '0, o);
      n_checks++; if (o.saw_wr || o.last_na !== 2'd0) begin n_fail++; $display("FAIL rh_setup: got wb=%b na=%0d expected wb=0 na=0", o.saw_wr, o.last_na); end
      model_access(0, 32'h300, '0, 0, 2'd0, '0, e);
      run_txn(1, 0, 0, 32'h300, '0, 0, 2'd0, '0, o);
      n_checks++; if (o.resp_cyc !== 2) begin n_fail++; $display("FAIL rh_latency: got %0d expected 2", o.resp_cyc); end
      n_checks++; if (o.rdata !== g || o.rdirty !== 1'b1) begin n_fail++; $display("FAIL rh_data: got %0h dirty=%b expected %0h dirty=1", o.rdata, o.rdirty, g); end
      n_checks++; if (o.n_load !== 0 || o.saw_rd) begin n_fail++; $display("FAIL rh_side: got n=%0d rd=%b expected 0", o.n_load, o.saw_rd); end
      fl = rnd_line();
      model_access(0, 32'h300, '0, 0, 2'd0, fl, e);
      run_txn(1, 0, 0, 32'h300, '0, 0, 2'd0, fl, o);
      n_checks++; if (!o.saw_rd || o.paddr !== 32'h300) begin n_fail++; $display("FAIL rh_reread_miss: got rd=%b addr=%0h expected rd=1 addr=300", o.saw_rd, o.paddr); end
      // E should still be sitting in way 2, clean.
      model_access(0, 32'h500, '0, 0, 2'd0, '0, e);
      run_txn(1, 0, 0, 32'h500, '0, 0, 2'd0, '0, o);
      n_checks++; if (o.rdata !== e.rdata || o.rdirty !== 1'b0 || o.saw_rd) begin n_fail++; $display("FAIL rh_e_resident: got %0h dirty=%b expected %0h dirty=0", o.rdata, o.rdirty, e.rdata); end
   endtask

   task automatic test_read_miss();
      exp_t e;
      obs_t o;
      logic [255:0] fl;
      fl = {8{32'hDEADBEEF}};
      for (int k = 0; k < 2; k++) begin
         model_access(0, 32'h900, '0, 0, 2'd0, fl, e);
         run_txn(1, 0, 0, 32'h900, '0, 0, 2'd0, fl, o);
         n_checks++; if (!o.saw_rd || o.saw_wr || o.paddr !== 32'h900) begin n_fail++; $display("FAIL rm_req[%0d]: got rd=%b wr=%b addr=%0h expected rd addr=900", k, o.saw_rd, o.saw_wr, o.paddr); end
         n_checks++; if (o.rdata !== fl || o.rdirty !== 1'b0) begin n_fail++; $display("FAIL rm_data[%0d]: got %0h dirty=%b expected %0h dirty=0", k, o.rdata, o.rdirty, fl); end
         n_checks++; if (o.n_load !== 0 || o.resp_cyc !== o.pmem_cyc + 1) begin n_fail++; $display("FAIL rm_side[%0d]: got n=%0d lat=%0d expected n=0 lat=%0d", k, o.n_load, o.resp_cyc, o.pmem_cyc + 1); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      obs_t o;
      logic [255:0] d;
      d = rnd_line();
      model_access(1, 32'hA00, d, 1, 2'd3, '0, e);
      run_txn(1, 1, 1, 32'hA00, d, 1, 2'd3, '0, o);
      n_checks++; if (o.n_load !== 1 || o.last_na !== e.way || o.saw_rd) begin n_fail++; $display("FAIL b2b_write_first: got n=%0d na=%0d rd=%b expected n=1 na=%0d rd=0", o.n_load, o.last_na, o.saw_rd, e.way); end
      model_access(0, 32'hA00, '0, 0, 2'd3, '0, e);
      run_txn(1, 0, 0, 32'hA00, '0, 0, 2'd3, '0, o);
      n_checks++; if (o.resp_cyc !== 2 || o.rdata !== d || o.rdirty !== 1'b1) begin n_fail++; $display("FAIL b2b_read: got lat=%0d %0h dirty=%b expected lat=2 %0h dirty=1", o.resp_cyc, o.rdata, o.rdirty, d); end
   endtask

   task automatic test_reset_mid_wb();
      exp_t e;
      obs_t o;
      logic [255:0] d;
      bit seen, bad;
      logic [31:0] addrs [4];
      addrs[0] = 32'hB00; addrs[1] = 32'h600; addrs[2] = 32'hC00; addrs[3] = 32'h400;
      for (int i = 0; i < 2; i++) begin
         d = rnd_line();
         model_access(1, (i == 0) ? 32'hB00 : 32'hC00, d, 0, 2'd0, '0, e);
         run_txn(0, 1, 0, (i == 0) ? 32'hB00 : 32'hC00, d, 0, 2'd0, '0, o);
         n_checks++; if (o.saw_wr || o.last_na !== e.way) begin n_fail++; $display("FAIL mid_setup[%0d]: got wb=%b na=%0d expected wb=0 na=%0d", i, o.saw_wr, o.last_na, e.way); end
      end
      @(negedge clk);
      l1_read = 1'b1; l1_write = 1'b1; l1_addr = 32'hD00;
      l1_wdata = rnd_line(); l1_wdirty = 1'b1; lru = 2'd1;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (pmem_write) seen = 1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_wb_start: got no pmem_write expected write-back"); end
      n_checks++; if (pmem_addr !== 32'h600 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL mid_wb_req: got addr=%0h rd=%b expected addr=600 rd=0", pmem_addr, pmem_read); end
      rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0;
      @(negedge clk);
      n_checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || l1_resp !== 1'b0 || load_lru !== 1'b0) begin n_fail++; $display("FAIL mid_wb_drop: got wr=%b rd=%b resp=%b load=%b expected 0", pmem_write, pmem_read, l1_resp, load_lru); end
      rst = 1'b0;
      model_clear();
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (l1_resp || load_lru || pmem_read || pmem_write) bad = 1;
      end
      n_checks++; if (bad) begin n_fail++; $display("FAIL mid_late_resp: got activity expected none"); end
      for (int i = 0; i < 4; i++) begin
         d = rnd_line();
         model_access(0, addrs[i], '0, 0, 2'd0, d, e);
         run_txn(1, 0, 0, addrs[i], '0, 0, 2'd0, d, o);
         n_checks++; if (o.saw_rd !== e.fill || o.rdata !== d) begin n_fail++; $display("FAIL mid_invalid[%0d]: got rd=%b %0h expected rd=%b %0h", i, o.saw_rd, o.rdata, e.fill, d); end
      end
   endtask

   task automatic test_random();
      exp_t e;
      obs_t o;
      bit wr, wd;
      logic [31:0] a;
      logic [255:0] d, fl;
      logic [1:0] lv;
      int exp_lat;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int n = 0; n < 300; n++) begin
         wr = ($urandom_range(0, 99) < 60);
         a  = 32'h0001_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
         d  = rnd_line();
         fl = rnd_line();
         wd = $urandom_range(0, 1);
         lv = 2'($urandom_range(0, 3));
         model_access(wr, a, d, wd, lv, fl, e);
         run_txn(!wr, wr, 0, a, d, wd, lv, fl, o);
         exp_lat = (e.wb || e.fill) ? o.pmem_cyc + 1 : 2;
         n_checks++; if (o.timeout || o.resp_cyc !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, o.resp_cyc, exp_lat); end
         n_checks++; if (o.saw_wr !== e.wb || o.saw_rd !== e.fill) begin n_fail++; $display("FAIL rnd_pmem_op[%0d]: got rd=%b wr=%b expected rd=%b wr=%b", n, o.saw_rd, o.saw_wr, e.fill, e.wb); end
         if (e.wb || e.fill) begin
            n_checks++; if (o.paddr !== e.paddr) begin n_fail++; $display("FAIL rnd_paddr[%0d]: got %0h expected %0h", n, o.paddr, e.paddr); end
         end
         if (e.wb) begin
            n_checks++; if (o.pwdata !== e.pwdata) begin n_fail++; $display("FAIL rnd_pwdata[%0d]: got %0h expected %0h", n, o.pwdata, e.pwdata); end
         end
         n_checks++; if (o.n_load !== e.n_load) begin n_fail++; $display("FAIL rnd_load_lru[%0d]: got %0d expected %0d", n, o.n_load, e.n_load); end
         if (wr) begin
            n_checks++; if (o.last_na !== e.way) begin n_fail++; $display("FAIL rnd_new_access[%0d]: got %0d expected %0d", n, o.last_na, e.way); end
         end else begin
            n_checks++; if (o.rdata !== e.rdata || o.rdirty !== e.rdirty) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %0h d=%b expected %0h d=%b", n, o.rdata, o.rdirty, e.rdata, e.rdirty); end
         end
         n_checks++; if (o.both || o.unstable) begin n_fail++; $display("FAIL rnd_pmem_stable[%0d]: got both=%b unstable=%b expected 0", n, o.both, o.unstable); end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_addr = '0; l1_wdata = '0;
      l1_wdirty = 1'b0; pmem_rdata = '0; pmem_resp = 1'b0; lru = 2'd0;
      test_reset();
      test_clean_inserts();
      test_clean_evict();
      test_dirty_wb();
      test_read_hit();
      test_read_miss();
      test_back_to_back();
      test_reset_mid_wb();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
